// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
// Op encodings, controller state encoding and the default operand width.
`timescale 1ns/1ps
package mdu_pkg;

    localparam int MD_DATA_W = 32;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4
    } mdOp_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } mdState_t;

endpackage

// File: rtl/div_core.sv
// Iterative radix-2 restoring divider with sign and divide-by-zero fixup.
// Owns the IDLE/BUSY/DONE controller; the state is exported for observation.
`timescale 1ns/1ps
module div_core
    import mdu_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              flush,
    input  logic              isSigned,
    input  logic [DATA_W-1:0] srcA,
    input  logic [DATA_W-1:0] srcB,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output mdState_t          state
);

    // Handshake: start is sampled only in IDLE and captures srcA/srcB on that edge;
    // busy is high for DATA_W cycles, then done is high for exactly one cycle with
    // hi/lo valid. flush in BUSY or DONE returns to IDLE and suppresses done.

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    mdState_t          nextState;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] dq;
    logic [DATA_W-1:0] divisor;
    logic [DATA_W-1:0] origA;
    logic              qneg;
    logic              rneg;
    logic              divZero;

    logic              signA;
    logic              signB;
    logic [DATA_W-1:0] absA;
    logic [DATA_W-1:0] absB;
    logic [DATA_W:0]   remShift;
    logic [DATA_W:0]   trial;

    assign signA = isSigned & srcA[DATA_W-1];
    assign signB = isSigned & srcB[DATA_W-1];
    assign absA  = signA ? -srcA : srcA;
    assign absB  = signB ? -srcB : srcB;

    // The top bit of trial is the borrow: set when the shifted remainder is below the divisor.
    assign remShift = {rem, dq[DATA_W-1]};
    assign trial    = remShift - {1'b0, divisor};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= MD_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start) nextState = MD_BUSY;
            end
            MD_BUSY: begin
                busy = 1'b1;
                if (flush)                  nextState = MD_IDLE;
                else if (count == LAST_CNT) nextState = MD_DONE;
            end
            MD_DONE: begin
                done      = ~flush;
                nextState = MD_IDLE;
            end
            default: nextState = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count   <= '0;
            rem     <= '0;
            dq      <= '0;
            divisor <= '0;
            origA   <= '0;
            qneg    <= 1'b0;
            rneg    <= 1'b0;
            divZero <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        count   <= '0;
                        rem     <= '0;
                        dq      <= absA;
                        divisor <= absB;
                        origA   <= srcA;
                        qneg    <= signA ^ signB;
                        rneg    <= signA;
                        divZero <= (srcB == '0);
                    end
                end
                MD_BUSY: begin
                    rem   <= trial[DATA_W] ? remShift[DATA_W-1:0] : trial[DATA_W-1:0];
                    dq    <= {dq[DATA_W-2:0], ~trial[DATA_W]};
                    count <= count + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Divide by zero returns the original dividend in HI and all ones in LO.
    assign lo = divZero ? {DATA_W{1'b1}} : (qneg ? -dq : dq);
    assign hi = divZero ? origA : (rneg ? -rem : rem);

endmodule

// File: rtl/mul_div_unit.sv
// E-stage multiply/divide unit: single-cycle multiplier, iterative divider,
// pipeline stall request and the HI/LO write path.
`timescale 1ns/1ps
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [2:0]        mdopE,
    input  logic [DATA_W-1:0] srcaE,
    input  logic [DATA_W-1:0] srcbE,
    input  logic              flushE,
    output logic              mut_div_stallE,
    output logic [DATA_W-1:0] hiE,
    output logic [DATA_W-1:0] loE,
    output logic              HLwriteE,
    output mdState_t          mdState
);

    logic                isMul;
    logic                isDiv;
    logic                mulSigned;
    logic                divSigned;
    logic                divStart;
    logic                divBusy;
    logic                divDone;
    logic                mulActive;
    logic [DATA_W-1:0]   divHi;
    logic [DATA_W-1:0]   divLo;
    logic [2*DATA_W-1:0] mulA;
    logic [2*DATA_W-1:0] mulB;
    logic [2*DATA_W-1:0] product;

    assign isMul     = (mdopE == MD_MULT) || (mdopE == MD_MULTU);
    assign isDiv     = (mdopE == MD_DIV)  || (mdopE == MD_DIVU);
    assign mulSigned = (mdopE == MD_MULT);
    assign divSigned = (mdopE == MD_DIV);
    assign divStart  = isDiv & ~flushE;

    // Extending both operands to 2*DATA_W makes one multiplier serve signed and unsigned.
    assign mulA    = {{DATA_W{mulSigned & srcaE[DATA_W-1]}}, srcaE};
    assign mulB    = {{DATA_W{mulSigned & srcbE[DATA_W-1]}}, srcbE};
    assign product = mulA * mulB;

    div_core #(
        .DATA_W (DATA_W)
    ) u_div_core (
        .clk      (clk),
        .resetn   (resetn),
        .start    (divStart),
        .flush    (flushE),
        .isSigned (divSigned),
        .srcA     (srcaE),
        .srcB     (srcbE),
        .busy     (divBusy),
        .done     (divDone),
        .hi       (divHi),
        .lo       (divLo),
        .state    (mdState)
    );

    assign mulActive      = (mdState == MD_IDLE) & isMul & ~flushE;
    assign mut_div_stallE = ((mdState == MD_IDLE) & divStart) | divBusy;

    always_comb begin
        hiE      = '0;
        loE      = '0;
        HLwriteE = 1'b0;
        if (mulActive) begin
            hiE      = product[2*DATA_W-1:DATA_W];
            loE      = product[DATA_W-1:0];
            HLwriteE = 1'b1;
        end else if (divDone) begin
            hiE      = divHi;
            loE      = divLo;
            HLwriteE = 1'b1;
        end
    end

endmodule
